// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute microcode sequencer for the bus CPU.
// Define SEQ_SINGLE_STEP_EN to add i_STEP_MODE/i_STEP manual single-stepping.
module control_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                  i_SYS_CLOCK,
    input  logic                  i_CLEAR_n,
    input  logic [DATA_WIDTH-1:0] i_INSTRUCTION,
    input  logic                  i_FLAG_C,
    input  logic                  i_FLAG_Z,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                  i_STEP_MODE,
    input  logic                  i_STEP,
`endif
    output logic                  o_MAR_IN,
    output logic                  o_RAM_IN,
    output logic                  o_RAM_OUT,
    output logic                  o_IR_IN,
    output logic                  o_IR_OUT,
    output logic                  o_PC_COUNT_ENABLE,
    output logic                  o_PC_JUMP_n,
    output logic                  o_PC_WRITE_BUS,
    output logic                  o_A_READ_BUS_n,
    output logic                  o_A_WRITE_BUS_n,
    output logic                  o_B_READ_BUS_n,
    output logic                  o_ALU_OUT,
    output logic                  o_ALU_SUB,
    output logic                  o_FLAGS_IN,
    output logic                  o_OUT_READ_BUS,
    output logic                  o_HALT,
    output logic [2:0]            o_STEP,
    output logic                  o_INSTR_DONE
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t step;
    step_t step_next;
    logic  halted;
    logic  halt_next;
    logic  advance;
    logic  live;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [3:0]              op;
    logic                    unused_operand;

    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic pc_count;
    logic pc_jump;
    logic pc_write;
    logic a_read;
    logic a_write;
    logic b_read;
    logic alu_out;
    logic alu_sub;
    logic flags_in;
    logic out_read;
    logic last;
    logic wrap;
    logic set_halt;

    assign opcode = i_INSTRUCTION[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign unused_operand = ^i_INSTRUCTION[DATA_WIDTH-OPCODE_WIDTH-1:0];

    // Wide opcode fields with any bit above the low nibble set are NOPs.
    assign op = ((opcode >> 4) != '0) ? OP_NOP : opcode[3:0];

`ifdef SEQ_SINGLE_STEP_EN
    logic step_meta;
    logic step_sync;
    logic step_prev;

    always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_meta <= i_STEP;
            step_sync <= step_meta;
            step_prev <= step_sync;
        end
    end

    assign advance = ~i_STEP_MODE | (step_sync & ~step_prev);
`else
    assign advance = 1'b1;
`endif

    always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            step   <= T0;
            halted <= 1'b0;
        end else begin
            step   <= step_next;
            halted <= halt_next;
        end
    end

    always_comb begin
        mar_in    = 1'b0;
        ram_in    = 1'b0;
        ram_out   = 1'b0;
        ir_in     = 1'b0;
        ir_out    = 1'b0;
        pc_count  = 1'b0;
        pc_jump   = 1'b0;
        pc_write  = 1'b0;
        a_read    = 1'b0;
        a_write   = 1'b0;
        b_read    = 1'b0;
        alu_out   = 1'b0;
        alu_sub   = 1'b0;
        flags_in  = 1'b0;
        out_read  = 1'b0;
        last      = 1'b0;
        wrap      = 1'b0;
        set_halt  = 1'b0;
        step_next = step;
        halt_next = halted;

        unique case (step)
            T0: begin
                pc_write = 1'b1;
                mar_in   = 1'b1;
            end
            T1: begin
                ram_out  = 1'b1;
                ir_in    = 1'b1;
                pc_count = 1'b1;
            end
            T2: begin
                unique case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ir_out = 1'b1;
                        mar_in = 1'b1;
                    end
                    OP_LDI: begin
                        ir_out = 1'b1;
                        a_read = 1'b1;
                        last   = 1'b1;
                    end
                    OP_JMP: begin
                        ir_out  = 1'b1;
                        pc_jump = 1'b1;
                        last    = 1'b1;
                    end
                    OP_JC: begin
                        ir_out  = i_FLAG_C;
                        pc_jump = i_FLAG_C;
                        last    = 1'b1;
                    end
                    OP_JZ: begin
                        ir_out  = i_FLAG_Z;
                        pc_jump = i_FLAG_Z;
                        last    = 1'b1;
                    end
                    OP_OUT: begin
                        a_write  = 1'b1;
                        out_read = 1'b1;
                        last     = 1'b1;
                    end
                    OP_HLT: set_halt = 1'b1;
                    default: last = 1'b1;
                endcase
            end
            T3: begin
                unique case (op)
                    OP_LDA: begin
                        ram_out = 1'b1;
                        a_read  = 1'b1;
                        last    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_out = 1'b1;
                        b_read  = 1'b1;
                        alu_sub = (op == OP_SUB);
                    end
                    OP_STA: begin
                        a_write = 1'b1;
                        ram_in  = 1'b1;
                        last    = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            T4: begin
                last = 1'b1;
                if (op == OP_ADD || op == OP_SUB) begin
                    alu_out  = 1'b1;
                    a_read   = 1'b1;
                    flags_in = 1'b1;
                    alu_sub  = (op == OP_SUB);
                end
            end
            default: wrap = 1'b1;
        endcase

        // Halted state freezes at T2; only reset leaves it.
        if (!halted && advance) begin
            if (set_halt) begin
                halt_next = 1'b1;
            end else if (last || wrap) begin
                step_next = T0;
            end else begin
                step_next = step_t'(step + 3'd1);
            end
        end
    end

    // Strobes drop immediately on reset and stay off while halted or stalled.
    assign live = i_CLEAR_n & ~halted & advance;

    assign o_MAR_IN          = live & mar_in;
    assign o_RAM_IN          = live & ram_in;
    assign o_RAM_OUT         = live & ram_out;
    assign o_IR_IN           = live & ir_in;
    assign o_IR_OUT          = live & ir_out;
    assign o_PC_COUNT_ENABLE = live & pc_count;
    assign o_PC_JUMP_n       = ~(live & pc_jump);
    assign o_PC_WRITE_BUS    = live & pc_write;
    assign o_A_READ_BUS_n    = ~(live & a_read);
    assign o_A_WRITE_BUS_n   = ~(live & a_write);
    assign o_B_READ_BUS_n    = ~(live & b_read);
    assign o_ALU_OUT         = live & alu_out;
    assign o_ALU_SUB         = live & alu_sub;
    assign o_FLAGS_IN        = live & flags_in;
    assign o_OUT_READ_BUS    = live & out_read;
    assign o_HALT            = halted;
    assign o_STEP            = step;
    assign o_INSTR_DONE      = i_CLEAR_n & ~halted & last;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed and random instructions checked
// against a micro-program table model.
module tb_control_sequencer;

    localparam int MAR  = 0;
    localparam int RAMI = 1;
    localparam int RAMO = 2;
    localparam int IRI  = 3;
    localparam int IRO  = 4;
    localparam int PCE  = 5;
    localparam int PCJ  = 6;
    localparam int PCW  = 7;
    localparam int AR   = 8;
    localparam int AW   = 9;
    localparam int BR   = 10;
    localparam int ALU  = 11;
    localparam int SUBB = 12;
    localparam int FLG  = 13;
    localparam int OUTR = 14;

    logic       clk;
    logic       clear_n;
    logic [7:0] instruction;
    logic       flag_c;
    logic       flag_z;
    logic       step_mode;
    logic       step_in;

    logic       o_MAR_IN, o_RAM_IN, o_RAM_OUT, o_IR_IN, o_IR_OUT;
    logic       o_PC_COUNT_ENABLE, o_PC_JUMP_n, o_PC_WRITE_BUS;
    logic       o_A_READ_BUS_n, o_A_WRITE_BUS_n, o_B_READ_BUS_n;
    logic       o_ALU_OUT, o_ALU_SUB, o_FLAGS_IN, o_OUT_READ_BUS;
    logic       o_HALT, o_INSTR_DONE;
    logic [2:0] o_STEP;

    int passed = 0;
    int total  = 0;

    logic [14:0] exp_seq [5];
    int          exp_len;

    control_sequencer #(.DATA_WIDTH(8), .OPCODE_WIDTH(4)) dut (
        .i_SYS_CLOCK       (clk),
        .i_CLEAR_n         (clear_n),
        .i_INSTRUCTION     (instruction),
        .i_FLAG_C          (flag_c),
        .i_FLAG_Z          (flag_z),
`ifdef SEQ_SINGLE_STEP_EN
        .i_STEP_MODE       (step_mode),
        .i_STEP            (step_in),
`endif
        .o_MAR_IN          (o_MAR_IN),
        .o_RAM_IN          (o_RAM_IN),
        .o_RAM_OUT         (o_RAM_OUT),
        .o_IR_IN           (o_IR_IN),
        .o_IR_OUT          (o_IR_OUT),
        .o_PC_COUNT_ENABLE (o_PC_COUNT_ENABLE),
        .o_PC_JUMP_n       (o_PC_JUMP_n),
        .o_PC_WRITE_BUS    (o_PC_WRITE_BUS),
        .o_A_READ_BUS_n    (o_A_READ_BUS_n),
        .o_A_WRITE_BUS_n   (o_A_WRITE_BUS_n),
        .o_B_READ_BUS_n    (o_B_READ_BUS_n),
        .o_ALU_OUT         (o_ALU_OUT),
        .o_ALU_SUB         (o_ALU_SUB),
        .o_FLAGS_IN        (o_FLAGS_IN),
        .o_OUT_READ_BUS    (o_OUT_READ_BUS),
        .o_HALT            (o_HALT),
        .o_STEP            (o_STEP),
        .o_INSTR_DONE      (o_INSTR_DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] b(input int i);
        return 15'(1) << i;
    endfunction

    // All strobes folded to active-high, one bit per strobe.
    function automatic logic [14:0] obs_word();
        return {o_OUT_READ_BUS, o_FLAGS_IN, o_ALU_SUB, o_ALU_OUT,
                ~o_B_READ_BUS_n, ~o_A_WRITE_BUS_n, ~o_A_READ_BUS_n,
                o_PC_WRITE_BUS, ~o_PC_JUMP_n, o_PC_COUNT_ENABLE,
                o_IR_OUT, o_IR_IN, o_RAM_OUT, o_RAM_IN, o_MAR_IN};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s got=%0h want=%0h", tag, got, want);
    endtask

    // Micro-program of one instruction; c/z are the flags seen at T2.
    task automatic build(input logic [7:0] ins, input bit c, input bit z);
        logic [14:0] mem;
        logic [14:0] sb;
        mem = b(IRO) | b(MAR);
        sb  = (ins[7:4] == 4'h3) ? b(SUBB) : 15'(0);
        for (int i = 0; i < 5; i++) exp_seq[i] = '0;
        exp_seq[0] = b(PCW) | b(MAR);
        exp_seq[1] = b(RAMO) | b(IRI) | b(PCE);
        exp_len = 3;
        case (ins[7:4])
            4'h1: begin
                exp_seq[2] = mem;
                exp_seq[3] = b(RAMO) | b(AR);
                exp_len = 4;
            end
            4'h2, 4'h3: begin
                exp_seq[2] = mem;
                exp_seq[3] = b(RAMO) | b(BR) | sb;
                exp_seq[4] = b(ALU) | b(AR) | b(FLG) | sb;
                exp_len = 5;
            end
            4'h4: begin
                exp_seq[2] = mem;
                exp_seq[3] = b(AW) | b(RAMI);
                exp_len = 4;
            end
            4'h5: exp_seq[2] = b(IRO) | b(AR);
            4'h6: exp_seq[2] = b(IRO) | b(PCJ);
            4'h7: exp_seq[2] = c ? (b(IRO) | b(PCJ)) : 15'(0);
            4'h8: exp_seq[2] = z ? (b(IRO) | b(PCJ)) : 15'(0);
            4'hE: exp_seq[2] = b(AW) | b(OUTR);
            default: exp_len = 3;
        endcase
    endtask

    task automatic check_step(input int t);
        chk("step", 32'(o_STEP), 32'(t));
        chk("strobes", 32'(obs_word()), 32'(exp_seq[t]));
        chk("done", 32'(o_INSTR_DONE), 32'(t == exp_len - 1));
    endtask

    // Entered between edges with the sequencer at T0; leaves at T0.
    task automatic run_instr(input logic [7:0] ins, input bit rnd,
                             input bit c2, input bit z2);
        build(ins, c2, z2);
        instruction = ins;
        for (int t = 0; t < exp_len; t++) begin
            flag_c = (rnd && t != 2) ? 1'($urandom_range(0, 1)) : c2;
            flag_z = (rnd && t != 2) ? 1'($urandom_range(0, 1)) : z2;
            #1;
            check_step(t);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] ins;
        clear_n     = 1'b0;
        instruction = 8'h00;
        flag_c      = 1'b0;
        flag_z      = 1'b0;
        step_mode   = 1'b0;
        step_in     = 1'b0;
        #1;
        chk("rst_step", 32'(o_STEP), 32'd0);
        chk("rst_halt", 32'(o_HALT), 32'd0);
        chk("rst_strobes", 32'(obs_word()), 32'd0);
        chk("rst_done", 32'(o_INSTR_DONE), 32'd0);
        #10;
        clear_n = 1'b1;

        run_instr(8'h57, 1'b0, 1'b0, 1'b0);
        chk("ldi_wrap", 32'(o_STEP), 32'd0);
        run_instr(8'h2E, 1'b0, 1'b0, 1'b0);
        run_instr(8'h3E, 1'b0, 1'b0, 1'b0);
        run_instr(8'h7A, 1'b0, 1'b0, 1'b1);
        run_instr(8'h7A, 1'b0, 1'b1, 1'b0);
        run_instr(8'h8A, 1'b0, 1'b1, 1'b0);
        run_instr(8'h8A, 1'b0, 1'b0, 1'b1);
        run_instr(8'h1C, 1'b0, 1'b0, 1'b0);
        run_instr(8'hE0, 1'b0, 1'b0, 1'b0);
        run_instr(8'hA5, 1'b0, 1'b1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            ins = {4'($urandom_range(0, 14)), 4'($urandom)};
            run_instr(ins, 1'b1, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        // Reset mid-T3 of STA must kill its write strobes at once.
        build(8'h4C, 1'b0, 1'b0);
        instruction = 8'h4C;
        for (int t = 0; t < 4; t++) begin
            #1;
            check_step(t);
            if (t < 3) begin
                @(posedge clk);
                #1;
            end
        end
        clear_n = 1'b0;
        #1;
        chk("sta_rst_ram_in", 32'(o_RAM_IN), 32'd0);
        chk("sta_rst_a_wr_n", 32'(o_A_WRITE_BUS_n), 32'd1);
        chk("sta_rst_strobes", 32'(obs_word()), 32'd0);
        chk("sta_rst_step", 32'(o_STEP), 32'd0);
        #1;
        clear_n = 1'b1;
        run_instr(8'h66, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_SINGLE_STEP_EN
        step_mode   = 1'b1;
        instruction = 8'h00;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("ss_idle_step", 32'(o_STEP), 32'd0);
            chk("ss_idle_strobes", 32'(obs_word()), 32'd0);
        end
        step_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ss_one_step", 32'(o_STEP), 32'd1);
        step_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ss_resume", 32'(o_STEP), 32'd0);
`endif

        // Halt: freezes at T2 until reset.
        build(8'hF0, 1'b0, 1'b0);
        exp_len     = 0;
        instruction = 8'hF0;
        flag_c      = 1'b0;
        flag_z      = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1;
            check_step(t);
            chk("hlt_pre_halt", 32'(o_HALT), 32'd0);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 20; k++) begin
            flag_c = 1'($urandom_range(0, 1));
            instruction = 8'($urandom);
            #1;
            chk("hlt_halt", 32'(o_HALT), 32'd1);
            chk("hlt_step", 32'(o_STEP), 32'd2);
            chk("hlt_strobes", 32'(obs_word()), 32'd0);
            chk("hlt_done", 32'(o_INSTR_DONE), 32'd0);
            @(posedge clk);
            #1;
        end
        clear_n = 1'b0;
        #1;
        chk("hlt_rst_halt", 32'(o_HALT), 32'd0);
        chk("hlt_rst_step", 32'(o_STEP), 32'd0);
        #1;
        clear_n = 1'b1;
        run_instr(8'h2E, 1'b0, 1'b0, 1'b0);
        run_instr(8'h57, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised microcode sequencer for the bus-based CPU.
- Replaces the hand-driven control lines (PC, A, B, output register) with a fetch/decode/execute state machine.
- Decodes the opcode field of the instruction register and the ALU flags, and emits every datapath control strobe per micro-step.
- Ends each instruction early when its last micro-step completes, and supports a latched halt.

Parameters:
- DATA_WIDTH, 8, instruction/bus width.
- OPCODE_WIDTH, 4, opcode field width (top bits of instruction); must be >=4 and <DATA_WIDTH.

Ports:
- i_SYS_CLOCK  in  1  clock; all state changes on rising edge.
- i_CLEAR_n  in  1  reset; asynchronous assert, active-low.
- i_INSTRUCTION  in  DATA_WIDTH  instruction register contents.
- i_FLAG_C  in  1  registered ALU carry flag.
- i_FLAG_Z  in  1  registered ALU zero flag.
- o_MAR_IN  out  1  memory address register loads from bus.
- o_RAM_IN  out  1  RAM writes bus.
- o_RAM_OUT  out  1  RAM drives bus.
- o_IR_IN  out  1  instruction register loads from bus.
- o_IR_OUT  out  1  IR operand field drives bus.
- o_PC_COUNT_ENABLE  out  1  PC increments.
- o_PC_JUMP_n  out  1  active-low, PC loads from bus.
- o_PC_WRITE_BUS  out  1  PC drives bus.
- o_A_READ_BUS_n  out  1  active-low, A loads from bus.
- o_A_WRITE_BUS_n  out  1  active-low, A drives bus.
- o_B_READ_BUS_n  out  1  active-low, B loads from bus.
- o_ALU_OUT  out  1  ALU drives bus.
- o_ALU_SUB  out  1  ALU subtracts.
- o_FLAGS_IN  out  1  flag register loads.
- o_OUT_READ_BUS  out  1  output display register loads.
- o_HALT  out  1  sequencer halted; drives clock-module halt.
- o_STEP  out  3  current micro-step (debug).
- o_INSTR_DONE  out  1  high during the final micro-step of an instruction.

Behaviour:
- Reset (i_CLEAR_n low, asynchronous):
  - step=0, halted=0.
  - All strobes forced inactive: active-high outputs 0, _n outputs 1.
  - o_HALT=0, o_STEP=0.
  - Reset mid-instruction aborts it; no partial strobes are emitted after reset asserts.
- Timing model:
  - Strobes are combinational decode of the step register, the opcode and the flags.
  - Datapath samples on the same rising edge that advances the step.
- Opcode = i_INSTRUCTION[DATA_WIDTH-1 -: OPCODE_WIDTH]. Any value above 4'hF, or unlisted, decodes as NOP.
- Fetch:
  - T0: PC_WRITE_BUS, MAR_IN.
  - T1: RAM_OUT, IR_IN, PC_COUNT_ENABLE.
- Execute (first listed step is T2):
  - 0 NOP: T2 none (last).
  - 1 LDA: T2 IR_OUT+MAR_IN; T3 RAM_OUT+A_READ_BUS_n=0 (last).
  - 2 ADD: T2 IR_OUT+MAR_IN; T3 RAM_OUT+B_READ_BUS_n=0; T4 ALU_OUT+A_READ_BUS_n=0+FLAGS_IN (last).
  - 3 SUB: as ADD, with ALU_SUB=1 in T3 and T4.
  - 4 STA: T2 IR_OUT+MAR_IN; T3 A_WRITE_BUS_n=0+RAM_IN (last).
  - 5 LDI: T2 IR_OUT+A_READ_BUS_n=0 (last).
  - 6 JMP: T2 IR_OUT+PC_JUMP_n=0 (last).
  - 7 JC: T2 jump strobes only if i_FLAG_C=1, else none (last).
  - 8 JZ: same as JC, gated by i_FLAG_Z.
  - E OUT: T2 A_WRITE_BUS_n=0+OUT_READ_BUS (last).
  - F HLT: T2 sets halted on the edge.
- Sequencing:
  - On the rising edge ending a last step, step returns to 0; otherwise step increments.
  - o_INSTR_DONE=1 throughout each last step.
  - Instruction lengths are therefore 3 cycles (NOP, LDI, JMP, JC, JZ, OUT), 4 cycles (LDA, STA) and 5 cycles (ADD, SUB).
- Halt:
  - Once halted, step is frozen at 2 and o_HALT=1.
  - All strobes are inactive and o_INSTR_DONE=0.
  - Only reset exits the halted state.
- Flags are sampled combinationally during T2 only; a flag change in other steps has no effect.
- The step register never exceeds 4; the illegal values 5-7 recover to 0 on the next edge.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined: adds ports i_STEP_MODE (1) and i_STEP (1).
  - When i_STEP_MODE=1, the step advances only on the edge after a rising transition of i_STEP, detected with a synchronised 2-flop edge detector reset to 0.
  - Strobes are valid only in the cycle the step advances, and held inactive otherwise, so datapath registers do not re-load.
  - When i_STEP_MODE=0, behaviour is identical to undefined.
- Undefined: the extra ports are absent; the step advances every clock.

Test Plan:
- Reset, then LDI 8'h57 on i_INSTRUCTION -> T0 PC_WRITE_BUS+MAR_IN; T1 RAM_OUT+IR_IN+PC_COUNT_ENABLE; T2 IR_OUT, A_READ_BUS_n=0, INSTR_DONE=1; next edge o_STEP=0.
- ADD 8'h2E -> 5-cycle sequence; T3 B_READ_BUS_n=0; T4 ALU_OUT+FLAGS_IN+A_READ_BUS_n=0, ALU_SUB=0; SUB 8'h3E -> same, but ALU_SUB=1 in T3 and T4.
- JC 8'h7A with i_FLAG_C=0 -> T2 PC_JUMP_n=1, IR_OUT=0; repeat with i_FLAG_C=1 -> PC_JUMP_n=0, IR_OUT=1; JZ 8'h8A checked the same way against i_FLAG_Z.
- HLT 8'hF0 -> after T2 edge o_HALT=1, o_STEP=2 held for 20 cycles, all strobes inactive; i_CLEAR_n pulse low -> o_HALT=0, o_STEP=0.
- Assert i_CLEAR_n low asynchronously mid-T3 of STA 8'h4C -> RAM_IN=0 and A_WRITE_BUS_n=1 immediately; after release the sequence resumes at T0.
- With SEQ_SINGLE_STEP_EN and i_STEP_MODE=1: 10 idle clocks -> o_STEP unchanged; one i_STEP pulse -> exactly one step advance.
